// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator slice.
package prod_accumulator_pkg;

    localparam int unsigned PROD_W = 6;

    typedef enum logic [1:0] {
        PA_IDLE = 2'd0,
        PA_ACC  = 2'd1,
        PA_DONE = 2'd2
    } pa_state_t;

endpackage

// File: rtl/prod_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product.
// Build option PROD_ACC_SAT_EN selects saturation on carry instead of wrap.
module prod_acc_add
    import prod_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = 10
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  next_acc,
    output logic              carry
);

    logic [ACC_W:0] sum;

    // Sum at ACC_W+1 bits so the carry out is visible; select wrap or saturate.
    always_comb begin
        sum   = {1'b0, acc} + (ACC_W+1)'(prod);
        carry = sum[ACC_W];
`ifdef PROD_ACC_SAT_EN
        next_acc = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        next_acc = sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accumulator.sv
// Batch accumulator behind the 3-bit array multiplier: sums products per
// batch and hands the total, term count and overflow flag downstream.
// Optional macro: PROD_ACC_SAT_EN (saturate accumulator on carry).
module prod_accumulator
    import prod_accumulator_pkg::*;
#(
    parameter  int unsigned ACC_W     = 10,
    parameter  int unsigned MAX_TERMS = 16,
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_terms,
    output logic              out_ovf
);

    pa_state_t        state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             valid_q;

    logic [ACC_W-1:0] next_acc;
    logic             carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             term_last;

    prod_acc_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc      (acc),
        .prod     (in_prod),
        .next_acc (next_acc),
        .carry    (carry)
    );

    // Ready whenever not holding a result; held low during reset.
    assign in_ready  = rst_n && (state != PA_DONE);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign term_last = in_last || (cnt_inc == CNT_W'(MAX_TERMS));

    // Batch FSM with accumulator, term counter and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PA_IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                PA_IDLE, PA_ACC: begin
                    if (accept) begin
                        acc <= next_acc;
                        cnt <= cnt_inc;
                        ovf <= ovf | carry;
                        if (term_last) begin
                            state   <= PA_DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state <= PA_ACC;
                        end
                    end
                end
                PA_DONE: begin
                    if (out_ready) begin
                        state   <= PA_IDLE;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= PA_IDLE;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = acc;
    assign out_terms = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: default instance plus a narrow
// instance (ACC_W=8, MAX_TERMS=6) for overflow and auto-termination.
module tb_prod_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
    logic [5:0] a_in_prod;
    logic [9:0] a_out_sum;
    logic [4:0] a_out_terms;

    logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic [5:0] b_in_prod;
    logic [7:0] b_out_sum;
    logic [2:0] b_out_terms;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  prod;
        logic        last;
        logic        ev;
        int unsigned es;
        int unsigned et;
        logic        eo;
    } vec_t;

    prod_accumulator dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_prod   (a_in_prod),
        .in_last   (a_in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_terms (a_out_terms),
        .out_ovf   (a_out_ovf)
    );

    prod_accumulator #(
        .ACC_W     (8),
        .MAX_TERMS (6)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_prod   (b_in_prod),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_terms (b_out_terms),
        .out_ovf   (b_out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic ev, input int unsigned es,
                           input int unsigned et, input logic eo);
        check({tag, ".valid"}, 32'(a_out_valid), 32'(ev));
        check({tag, ".sum"},   32'(a_out_sum),   es);
        check({tag, ".terms"}, 32'(a_out_terms), et);
        check({tag, ".ovf"},   32'(a_out_ovf),   32'(eo));
    endtask

    task automatic check_b(input string tag, input logic ev, input int unsigned es,
                           input int unsigned et, input logic eo);
        check({tag, ".valid"}, 32'(b_out_valid), 32'(ev));
        check({tag, ".sum"},   32'(b_out_sum),   es);
        check({tag, ".terms"}, 32'(b_out_terms), et);
        check({tag, ".ovf"},   32'(b_out_ovf),   32'(eo));
    endtask

    task automatic apply_a(input vec_t v, input string tag);
        a_in_valid = 1'b1;
        a_in_prod  = v.prod;
        a_in_last  = v.last;
        tick();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        check_a(tag, v.ev, v.es, v.et, v.eo);
    endtask

    task automatic apply_b(input vec_t v, input string tag);
        b_in_valid = 1'b1;
        b_in_prod  = v.prod;
        b_in_last  = v.last;
        tick();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        check_b(tag, v.ev, v.es, v.et, v.eo);
    endtask

    vec_t basic [3];
    vec_t wrap6 [6];
    vec_t last6 [6];
    vec_t v;

    initial begin
        // Hand-computed tables.
        basic[0] = '{6'd6,  1'b0, 1'b0, 6,  1, 1'b0};
        basic[1] = '{6'd49, 1'b0, 1'b0, 55, 2, 1'b0};
        basic[2] = '{6'd12, 1'b1, 1'b1, 67, 3, 1'b0};

        wrap6[0] = '{6'd49, 1'b0, 1'b0, 49,  1, 1'b0};
        wrap6[1] = '{6'd49, 1'b0, 1'b0, 98,  2, 1'b0};
        wrap6[2] = '{6'd49, 1'b0, 1'b0, 147, 3, 1'b0};
        wrap6[3] = '{6'd49, 1'b0, 1'b0, 196, 4, 1'b0};
        wrap6[4] = '{6'd49, 1'b0, 1'b0, 245, 5, 1'b0};
`ifdef PROD_ACC_SAT_EN
        wrap6[5] = '{6'd49, 1'b0, 1'b1, 255, 6, 1'b1};
`else
        wrap6[5] = '{6'd49, 1'b0, 1'b1, 38,  6, 1'b1};
`endif

        for (int i = 0; i < 6; i++)
            last6[i] = '{6'd10, (i == 5), (i == 5), 10 * (i + 1), i + 1, 1'b0};

        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_prod = '0; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_prod = '0; b_in_last = 1'b0; b_out_ready = 1'b0;

        // Reset state.
        #12;
        check("rst.a_ready", 32'(a_in_ready), 0);
        check("rst.b_ready", 32'(b_in_ready), 0);
        check_a("rst.a", 1'b0, 0, 0, 1'b0);
        check_b("rst.b", 1'b0, 0, 0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel.a_ready", 32'(a_in_ready), 1);
        check("rel.b_ready", 32'(b_in_ready), 1);

        // Basic back-to-back batch.
        foreach (basic[i]) apply_a(basic[i], $sformatf("basic%0d", i));

        // Backpressure in DONE with a pending term upstream.
        a_in_valid = 1'b1; a_in_prod = 6'd7; a_in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a($sformatf("hold%0d", i), 1'b1, 67, 3, 1'b0);
            check($sformatf("hold%0d.ready", i), 32'(a_in_ready), 0);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check_a("release", 1'b0, 0, 0, 1'b0);
        check("release.ready", 32'(a_in_ready), 1);
        tick();
        check_a("take7", 1'b0, 7, 1, 1'b0);
        v = '{6'd8, 1'b1, 1'b1, 15, 2, 1'b0};
        apply_a(v, "close15");
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;

        // Auto-termination at MAX_TERMS=16 on the default instance.
        for (int i = 0; i < 16; i++) begin
            v = '{6'd63, 1'b0, (i == 15), 63 * (i + 1), i + 1, 1'b0};
            apply_a(v, $sformatf("max16_%0d", i));
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;

        // Overflow and auto-termination on the narrow instance.
        foreach (wrap6[i]) apply_b(wrap6[i], $sformatf("ovf%0d", i));
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check_b("ovf.clear", 1'b0, 0, 0, 1'b0);

        // in_last coinciding with the MAX_TERMS-th term.
        foreach (last6[i]) apply_b(last6[i], $sformatf("last6_%0d", i));
        tick();
        check_b("last6.hold", 1'b1, 60, 6, 1'b0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check_b("last6.clear", 1'b0, 0, 0, 1'b0);

        // Reset mid-batch discards the partial sum.
        a_in_valid = 1'b1; a_in_prod = 6'd49; a_in_last = 1'b0;
        tick();
        tick();
        a_in_valid = 1'b0;
        check_a("mid.pre", 1'b0, 98, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_a("mid.rst", 1'b0, 0, 0, 1'b0);
        check("mid.rst_ready", 32'(a_in_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid.rel_ready", 32'(a_in_ready), 1);
        v = '{6'd5, 1'b1, 1'b1, 5, 1, 1'b0};
        apply_a(v, "mid.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
